// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS bit positions,
// receive FSM states and the divisor floor.
package uart_pkg;

   localparam logic [3:0]  RXDATA_OFF  = 4'h0;
   localparam logic [3:0]  STATUS_OFF  = 4'h4;
   localparam logic [3:0]  DIVISOR_OFF = 4'h8;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVR   = 2;
   localparam int ST_FERR  = 3;

   localparam logic [15:0] MIN_DIV = 16'd4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// CPU data-bus request signals (address, enable, direction) seen
// by a memory-mapped peripheral.
interface uart_rx_mmio_if;

   logic [31:0] MADDR;
   logic        MEN;
   logic        MRW;

   modport master (output MADDR, MEN, MRW);
   modport slave  (input  MADDR, MEN, MRW);

endinterface

// File: rtl/uart_rx_mmio_fifo.sv
// Synchronous FIFO with one-extra-bit wrapping pointers.
// A pop frees a slot for a push in the same cycle even when full.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push, do_pop;

   assign count   = wptr_q - rptr_q;
   assign full    = count[AW];
   assign empty   = (wptr_q == rptr_q);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
      rptr_d = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding an 8-entry FIFO, polled by the CPU
// through RXDATA / STATUS / DIVISOR on the shared data bus.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2010,
   parameter logic [15:0] DEFAULT_DIV = 16'd868,
   parameter int          FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        irst,
   input  logic [31:0] MADDR,
   inout  wire  [31:0] MDATA,
   input  logic        MEN,
   input  logic        MRW,
   inout  wire         MWAIT,
   input  logic        usb_rx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rx_state_e   state_q, state_d;
   logic [2:0]  sync_q, sync_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        ovr_q, ovr_d;
   logic        ferr_q, ferr_d;
   logic        ack_q, ack_d;
   logic        pend_q, pend_d;
   logic        rw_q, rw_d;
   logic [3:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;

   logic          rx_s, fall, tick;
   logic          push, ferr_set, pop, wr_en, sel;
   logic [7:0]    fifo_rdata;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_cnt;
   logic [31:0]   status;
   logic          unused_mdata;

   assign sync_d = {sync_q[1:0], usb_rx};
   assign rx_s   = sync_q[1];
   assign fall   = sync_q[2] & ~sync_q[1];
   assign tick   = (cnt_q == '0);

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (fall) state_d = START;
         START:   if (tick) state_d = rx_s ? IDLE : DATA;
         DATA:    if (tick && bit_q == 3'd7) state_d = STOP;
         STOP:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Divisor is re-read at every reload, so a mid-frame write lands there.
   always_comb begin
      cnt_d    = tick ? cnt_q : cnt_q - 16'd1;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      unique case (state_q)
         IDLE: if (fall) cnt_d = div_q >> 1;
         START: if (tick && !rx_s) begin
            cnt_d = div_q - 16'd1;
            bit_d = '0;
         end
         DATA: if (tick) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            cnt_d   = div_q - 16'd1;
            bit_d   = bit_q + 3'd1;
         end
         STOP: if (tick) begin
            push     = rx_s;
            ferr_set = ~rx_s;
         end
         default: ;
      endcase
   end

   assign sel   = MEN & (MADDR[31:4] == BASE_ADDR[31:4]) & ~ack_q;
   assign wr_en = pend_q & rw_q;
   // Pop only what was handed out, never a byte that arrived afterwards.
   assign pop   = pend_q & ~rw_q & (off_q == RXDATA_OFF) & rdata_q[31];

   always_comb begin
      status           = '0;
      status[ST_EMPTY] = fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_OVR]   = ovr_q;
      status[ST_FERR]  = ferr_q;
      status[7:4]      = 4'(fifo_cnt);
   end

   always_comb begin
      rdata_d = rdata_q;
      if (sel) begin
         rdata_d = '0;
         unique case (1'b1)
            MADDR[3:0] == RXDATA_OFF:
               if (!fifo_empty) rdata_d = {1'b1, 23'd0, fifo_rdata};
            MADDR[3:0] == STATUS_OFF:  rdata_d = status;
            MADDR[3:0] == DIVISOR_OFF: rdata_d = {16'd0, div_q};
            default: ;
         endcase
      end
   end

   always_comb begin
      ack_d  = sel | (ack_q & MEN);
      pend_d = sel;
      rw_d   = sel ? MRW : rw_q;
      off_d  = sel ? MADDR[3:0] : off_q;
      div_d  = div_q;
      ovr_d  = ovr_q;
      ferr_d = ferr_q;
      if (wr_en && off_q == DIVISOR_OFF)
         div_d = (MDATA[15:0] < MIN_DIV) ? MIN_DIV : MDATA[15:0];
      if (wr_en && off_q == STATUS_OFF) begin
         ovr_d  = ovr_q & ~MDATA[ST_OVR];
         ferr_d = ferr_q & ~MDATA[ST_FERR];
      end
      if (push && fifo_full && !pop) ovr_d = 1'b1;
      if (ferr_set) ferr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge irst) begin
      if (!irst) begin
         sync_q  <= 3'b111;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         div_q   <= DEFAULT_DIV;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ack_q   <= 1'b0;
         pend_q  <= 1'b0;
         rw_q    <= 1'b0;
         off_q   <= '0;
         rdata_q <= '0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         div_q   <= div_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         ack_q   <= ack_d;
         pend_q  <= pend_d;
         rw_q    <= rw_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
      end
   end

   assign MWAIT = sel ? 1'b1 : (ack_q ? 1'b0 : 1'bz);
   assign MDATA = (pend_q && !rw_q) ? rdata_q : 'z;
   assign unused_mdata = ^MDATA[31:16];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (irst),
      .push  (push),
      .wdata (shreg_q),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

endmodule
